// File: rtl/trigger_capture.sv
// trigger_capture: circular pre-trigger history, level-crossing trigger, fixed-depth record readout.
// Ports: clk_i/rst (sync, active high); SI_data/SI_rdy/SI_ack sample input (always acknowledged);
//   start, force_trigger, trigger_level, trigger_edge, pre_trigger capture controls;
//   busy/triggered/done status; RD_data/RD_rdy/RD_ack oldest-first record readout.
module trigger_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] SI_data,
  input  logic                  SI_rdy,
  output logic                  SI_ack,
  input  logic                  start,
  input  logic                  force_trigger,
  input  logic [DATA_WIDTH-1:0] trigger_level,
  input  logic                  trigger_edge,
  input  logic [ADDR_WIDTH-1:0] pre_trigger,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] RD_data,
  output logic                  RD_rdy,
  input  logic                  RD_ack
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, READOUT} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pre_q, wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] cnt, post_len;
  logic [DATA_WIDTH-1:0] prev;
  logic prev_valid, rd_wait, we, hit, xfer;
  assign SI_ack = SI_rdy & ~rst;
  assign we = SI_ack & (state == PRE || state == ARMED || state == POST);
  assign post_len = DEPTH_W - {1'b0, pre_q};
  assign xfer = RD_rdy & RD_ack;
  assign hit = force_trigger | (prev_valid & (trigger_edge ?
    (prev > trigger_level && SI_data <= trigger_level) :
    (prev < trigger_level && SI_data >= trigger_level)));
  always_ff @(posedge clk_i) if (we) mem[wr_ptr] <= SI_data;
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      triggered <= 1'b0;
      done <= 1'b0;
      RD_rdy <= 1'b0;
      RD_data <= '0;
      pre_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      prev <= '0;
      prev_valid <= 1'b0;
      rd_wait <= 1'b0;
    end else begin
      done <= 1'b0;
      if (we) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE: if (start) begin
          pre_q <= pre_trigger;
          wr_ptr <= '0;
          cnt <= '0;
          prev_valid <= 1'b0;
          busy <= 1'b1;
          state <= (pre_trigger == '0) ? ARMED : PRE;
        end
        PRE: if (SI_ack) begin
          cnt <= cnt + 1'b1;
          if (cnt + 1'b1 == {1'b0, pre_q}) state <= ARMED;
        end
        ARMED: if (SI_ack) begin
          prev <= SI_data;
          prev_valid <= 1'b1;
          if (hit) begin
            // wr_ptr still addresses the trigger sample; the record starts pre_q slots earlier
            triggered <= 1'b1;
            rd_ptr <= wr_ptr - pre_q;
            rd_wait <= 1'b1;
            cnt <= (post_len == ONE) ? '0 : ONE;
            state <= (post_len == ONE) ? READOUT : POST;
          end
        end
        POST: if (SI_ack) begin
          cnt <= (cnt + 1'b1 == post_len) ? '0 : cnt + 1'b1;
          if (cnt + 1'b1 == post_len) state <= READOUT;
        end
        READOUT: begin
          if (xfer) begin
            RD_rdy <= 1'b0;
            rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + 1'b1;
            if (cnt == DEPTH_W - 1'b1) begin
              done <= 1'b1;
              busy <= 1'b0;
              triggered <= 1'b0;
              state <= IDLE;
            end
          end else if (!RD_rdy) begin
            // first word spends one extra cycle presenting the start address
            if (rd_wait) rd_wait <= 1'b0;
            else begin
              RD_data <= mem[rd_ptr];
              RD_rdy <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: randomized self-checking bench for trigger_capture against a sample-list model.
module tb_trigger_capture;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  logic clk_i = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] SI_data = '0;
  logic SI_rdy = 1'b0;
  logic SI_ack;
  logic start = 1'b0;
  logic force_trigger = 1'b0;
  logic [DW-1:0] trigger_level = '0;
  logic trigger_edge = 1'b0;
  logic [AW-1:0] pre_trigger = '0;
  logic busy, triggered, done, RD_rdy;
  logic [DW-1:0] RD_data;
  logic RD_ack = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  trigger_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst(rst), .SI_data(SI_data), .SI_rdy(SI_rdy), .SI_ack(SI_ack),
    .start(start), .force_trigger(force_trigger), .trigger_level(trigger_level),
    .trigger_edge(trigger_edge), .pre_trigger(pre_trigger), .busy(busy),
    .triggered(triggered), .done(done), .RD_data(RD_data), .RD_rdy(RD_rdy), .RD_ack(RD_ack)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] gen(input int mode, input int idx);
    case (mode)
      0: return DW'(idx * 16);
      1: return DW'(240 - idx * 16);
      2: return 8'h20;
      default: return DW'($urandom);
    endcase
  endfunction
  // model: s holds every sample written since start; the record is a window of it around the trigger
  task automatic capture(input int pre, input logic [DW-1:0] lvl, input logic edg, input int mode,
                         input int p_rdy, input int p_ack, input int abort);
    logic [DW-1:0] s[$];
    int trig = -1, nread = 0, since = 0, need = 3, cyc = 0, idx;
    bit complete = 0, exp_rdy;
    pre_trigger = AW'(pre);
    trigger_level = lvl;
    trigger_edge = edg;
    start = 1'b1;
    SI_rdy = 1'b1;
    SI_data = 8'hAA;
    force_trigger = 1'b0;
    RD_ack = 1'b0;
    @(negedge clk_i);
    check("start_ack", SI_ack, 1);
    check("start_busy", busy, 0);
    @(posedge clk_i); #1;
    start = 1'b0;
    while (nread < DEPTH && cyc < 2000) begin
      cyc++;
      if ((abort == 1 && trig >= 0 && !complete) || (abort == 2 && complete && since >= 5)) begin
        rst = 1'b1;
        SI_rdy = 1'b1;
        #1;
        check("rst_ack", SI_ack, 0);
        @(posedge clk_i); #1;
        rst = 1'b0;
        SI_rdy = 1'b0;
        @(negedge clk_i);
        check("abort_busy", busy, 0);
        check("abort_trig", triggered, 0);
        check("abort_rdy", RD_rdy, 0);
        check("abort_data", RD_data, 0);
        @(posedge clk_i); #1;
        return;
      end
      SI_rdy = ($urandom_range(99) < p_rdy);
      SI_data = gen(mode, s.size());
      force_trigger = (mode == 2 && s.size() >= pre + 6) || (mode == 3 && s.size() >= pre + 40);
      start = ($urandom_range(5) == 0);
      RD_ack = ($urandom_range(99) < p_ack);
      @(negedge clk_i);
      if (complete) since++;
      exp_rdy = complete && since >= need;
      check("busy", busy, 1);
      check("triggered", triggered, trig >= 0);
      check("rd_rdy", RD_rdy, exp_rdy);
      if (SI_rdy && !complete) begin
        idx = s.size();
        s.push_back(SI_data);
        if (trig < 0 && idx >= pre && (force_trigger || (idx > pre && (edg ?
            (s[idx-1] > lvl && SI_data <= lvl) : (s[idx-1] < lvl && SI_data >= lvl)))))
          trig = idx;
        if (trig >= 0 && s.size() == trig + DEPTH - pre) begin
          complete = 1;
          since = 0;
        end
      end
      if (RD_rdy && RD_ack && exp_rdy) begin
        check("rd_data", RD_data, s[trig - pre + nread]);
        nread++;
        since = 0;
        need = 2;
      end
      @(posedge clk_i); #1;
    end
    start = 1'b0;
    RD_ack = 1'b0;
    force_trigger = 1'b1;
    SI_rdy = 1'b1;
    check("no_timeout", nread, DEPTH);
    @(negedge clk_i);
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("done_trig", triggered, 0);
    check("done_rdy", RD_rdy, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("idle_trig", triggered, 0);
    check("idle_ack", SI_ack, 1);
    @(posedge clk_i); #1;
    force_trigger = 1'b0;
    SI_rdy = 1'b0;
  endtask
  initial begin
    SI_rdy = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("rst_busy", busy, 0);
    check("rst_trig", triggered, 0);
    check("rst_done", done, 0);
    check("rst_rdy", RD_rdy, 0);
    check("rst_data", RD_data, 0);
    check("rst_ack0", SI_ack, 0);
    @(posedge clk_i); #1;
    rst = 1'b0;
    force_trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SI_data = DW'(i);
      @(negedge clk_i);
      check("idle_ack_hold", SI_ack, 1);
      check("idle_force_busy", busy, 0);
      check("idle_force_trig", triggered, 0);
      @(posedge clk_i); #1;
    end
    force_trigger = 1'b0;
    capture(4, 8'h80, 1'b0, 0, 100, 100, 0);
    capture(0, 8'h80, 1'b1, 1, 100, 100, 0);
    capture(3, 8'h80, 1'b0, 2, 100, 100, 0);
    capture(4, 8'h80, 1'b0, 0, 100, 100, 1);
    capture(4, 8'h80, 1'b0, 0, 100, 0, 2);
    capture(4, 8'h80, 1'b0, 0, 70, 60, 0);
    capture(15, 8'h80, 1'b0, 0, 100, 100, 0);
    capture(15, 8'h80, 1'b1, 2, 80, 50, 0);
    for (int i = 0; i < 8; i++)
      capture($urandom_range(DEPTH - 1), DW'($urandom), 1'($urandom), 3, 60, 60, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
